// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 3-digit display scan scheduler with blanking and double-buffered BCD load
module digit_scan_ctrl #(
    parameter int SHOW_CYCLES  = 49000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [11:0] bcd_in,
    output logic [1:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        blank,
    output logic        frame_done,
    output logic        load_ack,
    output logic        load_err
);

    // One counter serves both BLANK and SHOW, so it is sized for the longer of the two.
    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [1:0]    IDX_ONES   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [11:0] active_q;
    logic [11:0] shadow_q;
    logic        pending_q;
    logic [1:0]  digit_sel_q;
    logic [3:0]  bcd_out_q;
    logic        blank_q;
    logic        frame_done_q;
    logic        load_ack_q;
    logic        load_err_q;

    logic        load_valid;
    logic        frame_end;
    logic        commit;
    logic [3:0]  slot_nibble;
    logic        slot_lz_blank;

    // Decode the incoming value, the frame boundary and the commit condition.
    always_comb begin
        load_valid = (bcd_in[11:8] <= 4'd9) && (bcd_in[7:4] <= 4'd9) && (bcd_in[3:0] <= 4'd9);
        // Dropping enable on the final ones cycle takes priority: the frame is abandoned,
        // and the pending value is committed from IDLE on the following cycle instead.
        frame_end  = (state_q == S_SHOW) && enable && (cnt_q == SHOW_LAST) && (idx_q == IDX_ONES);
        commit     = pending_q && ((state_q == S_IDLE) || frame_end);
        idx_d      = (idx_q == IDX_ONES) ? 2'd0 : idx_q + 2'd1;
    end

    // Pick the nibble for the current slot and decide whether leading-zero suppression blanks it.
    always_comb begin
        slot_nibble   = 4'd0;
        slot_lz_blank = 1'b0;
        case (idx_q)
            2'd0: begin
                slot_nibble   = active_q[11:8];
                slot_lz_blank = (LZ_SUPPRESS != 0) && (active_q[11:8] == 4'd0);
            end
            2'd1: begin
                slot_nibble   = active_q[7:4];
                slot_lz_blank = (LZ_SUPPRESS != 0) && (active_q[11:4] == 8'd0);
            end
            2'd2: begin
                slot_nibble   = active_q[3:0];
                slot_lz_blank = 1'b0;
            end
            default: begin
                slot_nibble   = 4'd0;
                slot_lz_blank = 1'b0;
            end
        endcase
    end

    // Scan FSM; display outputs are set on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            digit_sel_q  <= 2'd0;
            bcd_out_q    <= 4'd0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            case (state_q)
                S_IDLE: begin
                    cnt_q       <= '0;
                    idx_q       <= 2'd0;
                    digit_sel_q <= 2'd0;
                    bcd_out_q   <= 4'd0;
                    blank_q     <= 1'b1;
                    if (enable) begin
                        state_q <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (!enable) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        idx_q       <= 2'd0;
                        digit_sel_q <= 2'd0;
                        bcd_out_q   <= 4'd0;
                        blank_q     <= 1'b1;
                    end else if (cnt_q == BLANK_LAST) begin
                        state_q     <= S_SHOW;
                        cnt_q       <= '0;
                        digit_sel_q <= idx_q;
                        bcd_out_q   <= slot_nibble;
                        blank_q     <= slot_lz_blank;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (!enable) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        idx_q       <= 2'd0;
                        digit_sel_q <= 2'd0;
                        bcd_out_q   <= 4'd0;
                        blank_q     <= 1'b1;
                    end else if (cnt_q == SHOW_LAST) begin
                        state_q     <= S_BLANK;
                        cnt_q       <= '0;
                        idx_q       <= idx_d;
                        digit_sel_q <= idx_d;
                        bcd_out_q   <= 4'd0;
                        blank_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    idx_q       <= 2'd0;
                    digit_sel_q <= 2'd0;
                    bcd_out_q   <= 4'd0;
                    blank_q     <= 1'b1;
                end
            endcase
        end
    end

    // Shadow/active double buffer: commit uses the pre-edge shadow, a same-edge load refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 12'd0;
            shadow_q   <= 12'd0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            load_ack_q <= commit;
            load_err_q <= load && !load_valid;
            if (commit) begin
                active_q <= shadow_q;
            end
            if (load && load_valid) begin
                shadow_q  <= bcd_in;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign digit_sel  = digit_sel_q;
    assign bcd_out    = bcd_out_q;
    assign blank      = blank_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;
    assign load_err   = load_err_q;

endmodule
